// File: rtl/dmem_pkg.sv
// Shared types for the data-memory initiator: FSM states, sign_mask bits, funct3 codes.
// Pure declarations; no latency or backpressure of its own.
// Both the encoder and the initiator import this package.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_HI = 2'd2,
      ST_WAIT_LO = 2'd3
   } state_e;

   localparam logic [3:0] SM_BYTE   = 4'b0001;
   localparam logic [3:0] SM_HALF   = 4'b0010;
   localparam logic [3:0] SM_WORD   = 4'b0100;
   localparam logic [3:0] SM_SIGNED = 4'b1000;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef struct packed {
      logic        we;
      logic [3:0]  mask;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
   function automatic logic misaligned(input logic [3:0] mask, input logic [1:0] lsb);
      return (mask[1] & lsb[0]) | (mask[2] & (lsb != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_sign_mask_enc.sv
// Maps RV32I load/store funct3 plus direction onto the memory's 4-bit sign_mask.
// Purely combinational, zero latency; no handshake.
// Unsupported codes raise illegal_o and return an all-zero mask.
module dmem_sign_mask_enc
   import dmem_pkg::*;
(
   input  logic       we_i,
   input  logic [2:0] funct3_i,
   output logic [3:0] sign_mask_o,
   output logic       illegal_o
);

   always_comb begin
      sign_mask_o = 4'b0000;
      illegal_o   = 1'b0;
      case (funct3_i)
         F3_B:  sign_mask_o = we_i ? SM_BYTE : (SM_SIGNED | SM_BYTE);
         F3_H:  sign_mask_o = we_i ? SM_HALF : (SM_SIGNED | SM_HALF);
         F3_W:  sign_mask_o = we_i ? SM_WORD : (SM_SIGNED | SM_WORD);
         // Unsigned variants exist only for loads.
         F3_BU: begin
            sign_mask_o = we_i ? 4'b0000 : SM_BYTE;
            illegal_o   = we_i;
         end
         F3_HU: begin
            sign_mask_o = we_i ? 4'b0000 : SM_HALF;
            illegal_o   = we_i;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_initiator.sv
// One-at-a-time load/store initiator toward the stalling data memory; optional DMEM_MISALIGN_CHECK_EN.
// Latency: accept cycle 0, strobe cycle 1, rsp_valid cycle 5 with a 2-cycle stall; bad requests answer in cycle 1.
// Backpressure: req_ready only in IDLE with mem_clk_stall low; timeouts after TIMEOUT_CYCLES in either wait state.
module dmem_initiator
   import dmem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic        mem_memwrite,
   output logic        mem_memread,
   output logic [3:0]  mem_sign_mask,
   input  logic [31:0] mem_read_data,
   input  logic        mem_clk_stall
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   state_e         state_q, state_d;
   req_t           req_q, req_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           rsp_err_q, rsp_err_d;
   logic [31:0]    rsp_rdata_q, rsp_rdata_d;

   logic [3:0]     enc_mask;
   logic           enc_illegal;
   logic           req_bad;
   logic           accept;
   logic           timeout;

   dmem_sign_mask_enc u_enc (
      .we_i        (req_we),
      .funct3_i    (req_funct3),
      .sign_mask_o (enc_mask),
      .illegal_o   (enc_illegal)
   );

`ifdef DMEM_MISALIGN_CHECK_EN
   assign req_bad = enc_illegal | misaligned(enc_mask, req_addr[1:0]);
`else
   assign req_bad = enc_illegal;
`endif

   // After a mid-transaction reset the memory may still be stalled; holding off here keeps its strobe from being lost.
   assign req_ready = (state_q == ST_IDLE) & ~mem_clk_stall & ~rst;
   assign accept    = req_valid & req_ready;
   assign timeout   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (req_bad) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  req_d   = '{we: req_we, mask: enc_mask, addr: req_addr, wdata: req_wdata};
                  state_d = ST_ISSUE;
                  cnt_d   = '0;
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_HI;
            cnt_d   = '0;
         end
         ST_WAIT_HI: begin
            if (mem_clk_stall) begin
               state_d = ST_WAIT_LO;
               cnt_d   = '0;
            end else if (timeout) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = ST_IDLE;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WAIT_LO: begin
            if (!mem_clk_stall) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = req_q.we ? 32'h0 : mem_read_data;
               state_d     = ST_IDLE;
               cnt_d       = '0;
            end else if (timeout) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = ST_IDLE;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // The strobe lives only in ISSUE, so the memory sees exactly one request per transaction.
   assign mem_memread    = (state_q == ST_ISSUE) & ~req_q.we;
   assign mem_memwrite   = (state_q == ST_ISSUE) &  req_q.we;
   assign mem_addr       = req_q.addr;
   assign mem_write_data = req_q.wdata;
   assign mem_sign_mask  = req_q.mask;

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule
